// File: rtl/exu_longp_wbck_ctrl_pkg.sv
// Shared widths and source indices for the long-pipe write-back controller.
// The tag, regfile-index and data width macros can be overridden before this file is compiled.
`ifndef ITAG_WIDTH
`define ITAG_WIDTH 4
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef XLEN
`define XLEN 32
`endif

package exu_longp_wbck_ctrl_pkg;
  localparam int LONGP_SRC_LSU    = 0;
  localparam int LONGP_SRC_MULDIV = 1;
  localparam int LONGP_NUM_SRC    = 2;
  localparam int ITAG_WIDTH_P     = `ITAG_WIDTH;
  localparam int RFIDX_WIDTH_P    = `RFIDX_WIDTH;
  localparam int XLEN_P           = `XLEN;

  typedef logic [ITAG_WIDTH_P-1:0]  itag_t;
  typedef logic [RFIDX_WIDTH_P-1:0] rfidx_t;
endpackage

// File: rtl/exu_longp_wbck_ctrl_slot.sv
// Single-entry result holding register (valid/itag/wdat/err) for one long-pipe source.
// A load in the same cycle as a drain refills the slot, so the source sees full throughput.
module exu_longp_slot #(
  parameter int ITAG_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic [ITAG_W-1:0] i_itag,
  input  logic [DATA_W-1:0] i_wdat,
  input  logic              i_err,
  output logic              o_vld,
  output logic [ITAG_W-1:0] o_itag,
  output logic [DATA_W-1:0] o_wdat,
  output logic              o_err
);
  logic              r_vld;
  logic [ITAG_W-1:0] r_itag;
  logic [DATA_W-1:0] r_wdat;
  logic              r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
    end else if (i_load | i_drain) begin
      r_vld <= i_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_itag <= '0;
      r_wdat <= '0;
      r_err  <= 1'b0;
    end else if (i_load) begin
      r_itag <= i_itag;
      r_wdat <= i_wdat;
      r_err  <= i_err;
    end
  end

  assign o_vld  = r_vld;
  assign o_itag = r_itag;
  assign o_wdat = r_wdat;
  assign o_err  = r_err;
endmodule

// File: rtl/exu_longp_wbck_ctrl.sv
// In-order write-back of long-latency EXU results: only the slot tagged with the OITF retire
// pointer may write the regfile and retire. Optional error path under LONGP_WBCK_ERR_EN.
module exu_longp_wbck_ctrl
  import exu_longp_wbck_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 32,
  parameter int ITAG_W  = `ITAG_WIDTH,
  parameter int RFIDX_W = `RFIDX_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_i_valid,
  output logic [NUM_SRC-1:0]        src_i_ready,
  input  logic [NUM_SRC*ITAG_W-1:0] src_i_itag,
  input  logic [NUM_SRC*DATA_W-1:0] src_i_wdat,
`ifdef LONGP_WBCK_ERR_EN
  input  logic [NUM_SRC-1:0]        src_i_err,
  output logic                      excp_valid,
  output logic [ITAG_W-1:0]         excp_itag,
`endif
  input  logic                      oitf_empty,
  input  logic [ITAG_W-1:0]         oitf_ret_ptr,
  input  logic [RFIDX_W-1:0]        oitf_ret_rdidx,
  input  logic                      oitf_ret_rdwen,
  output logic                      oitf_ret_ena,
  output logic                      rf_wbck_valid,
  input  logic                      rf_wbck_ready,
  output logic [RFIDX_W-1:0]        rf_wbck_rdidx,
  output logic [DATA_W-1:0]         rf_wbck_wdat,
  output logic [31:0]               ret_cnt
);
  logic [NUM_SRC-1:0]        w_slot_vld;
  logic [NUM_SRC-1:0]        w_slot_err;
  logic [NUM_SRC-1:0]        w_src_err;
  logic [NUM_SRC-1:0]        w_load;
  logic [NUM_SRC-1:0]        w_match;
  logic [NUM_SRC-1:0]        w_drain;
  logic [NUM_SRC*ITAG_W-1:0] w_slot_itag;
  logic [NUM_SRC*DATA_W-1:0] w_slot_wdat;
  logic [DATA_W-1:0]         w_sel_wdat;
  logic                      w_sel_err;
  logic                      w_any_match;
  logic [31:0]               r_ret_cnt;

`ifdef LONGP_WBCK_ERR_EN
  assign w_src_err = src_i_err;
`else
  assign w_src_err = '0;
`endif

  assign w_load = src_i_valid & src_i_ready;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
    exu_longp_slot #(
      .ITAG_W (ITAG_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[k]),
      .i_drain (w_drain[k]),
      .i_itag  (src_i_itag[k*ITAG_W +: ITAG_W]),
      .i_wdat  (src_i_wdat[k*DATA_W +: DATA_W]),
      .i_err   (w_src_err[k]),
      .o_vld   (w_slot_vld[k]),
      .o_itag  (w_slot_itag[k*ITAG_W +: ITAG_W]),
      .o_wdat  (w_slot_wdat[k*DATA_W +: DATA_W]),
      .o_err   (w_slot_err[k])
    );
  end

  // Matching is suppressed during reset so a held result can never retire while being dropped.
  always_comb begin
    w_match    = '0;
    w_sel_wdat = '0;
    w_sel_err  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_match[k] = w_slot_vld[k] & ~oitf_empty & ~rst &
                   (w_slot_itag[k*ITAG_W +: ITAG_W] == oitf_ret_ptr);
      if (w_match[k]) begin
        w_sel_wdat = w_sel_wdat | w_slot_wdat[k*DATA_W +: DATA_W];
        w_sel_err  = w_sel_err  | w_slot_err[k];
      end
    end
  end

  assign w_any_match   = |w_match;
  assign rf_wbck_valid = w_any_match & oitf_ret_rdwen & ~w_sel_err;
  assign rf_wbck_rdidx = oitf_ret_rdidx;
  assign rf_wbck_wdat  = w_sel_wdat;
  assign w_drain       = w_match & {NUM_SRC{rf_wbck_ready | ~oitf_ret_rdwen | w_sel_err}};
  assign oitf_ret_ena  = |w_drain;
  assign src_i_ready   = ~w_slot_vld | w_drain | {NUM_SRC{rst}};

`ifdef LONGP_WBCK_ERR_EN
  always_comb begin
    excp_itag = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_match[k]) begin
        excp_itag = excp_itag | w_slot_itag[k*ITAG_W +: ITAG_W];
      end
    end
  end
  assign excp_valid = w_any_match & w_sel_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ret_cnt <= '0;
    end else if (oitf_ret_ena) begin
      r_ret_cnt <= r_ret_cnt + 32'd1;
    end
  end

  assign ret_cnt = r_ret_cnt;

  // OITF tags are unique, so two slots claiming the retire pointer means an upstream bug.
  a_match_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(w_match));
endmodule

// File: tb/tb_exu_longp_wbck_ctrl.sv
// Scenario bench for exu_longp_wbck_ctrl; the error scenario runs only with LONGP_WBCK_ERR_EN.
// Expected regfile writes go into a scoreboard queue when stimulus is driven.
module tb_exu_longp_wbck_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  srcValid;
  logic [1:0]  srcReady;
  logic [7:0]  srcItag;
  logic [63:0] srcWdat;
  logic        oitfEmpty;
  logic [3:0]  oitfRetPtr;
  logic [4:0]  oitfRetRdidx;
  logic        oitfRetRdwen;
  logic        oitfRetEna;
  logic        rfWbckValid;
  logic        rfWbckReady;
  logic [4:0]  rfWbckRdidx;
  logic [31:0] rfWbckWdat;
  logic [31:0] retCnt;
`ifdef LONGP_WBCK_ERR_EN
  logic [1:0]  srcErr;
  logic        excpValid;
  logic [3:0]  excpItag;
`endif

  typedef struct {
    logic [4:0]  rdidx;
    logic [31:0] wdat;
  } wbExp_t;

  wbExp_t expQ[$];
  wbExp_t monExp;
  int     checks   = 0;
  int     failures = 0;
  int     expCnt   = 0;

  always #5 clk = ~clk;

  exu_longp_wbck_ctrl #(
    .NUM_SRC (2),
    .DATA_W  (32),
    .ITAG_W  (4),
    .RFIDX_W (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .src_i_valid    (srcValid),
    .src_i_ready    (srcReady),
    .src_i_itag     (srcItag),
    .src_i_wdat     (srcWdat),
`ifdef LONGP_WBCK_ERR_EN
    .src_i_err      (srcErr),
    .excp_valid     (excpValid),
    .excp_itag      (excpItag),
`endif
    .oitf_empty     (oitfEmpty),
    .oitf_ret_ptr   (oitfRetPtr),
    .oitf_ret_rdidx (oitfRetRdidx),
    .oitf_ret_rdwen (oitfRetRdwen),
    .oitf_ret_ena   (oitfRetEna),
    .rf_wbck_valid  (rfWbckValid),
    .rf_wbck_ready  (rfWbckReady),
    .rf_wbck_rdidx  (rfWbckRdidx),
    .rf_wbck_wdat   (rfWbckWdat),
    .ret_cnt        (retCnt)
  );

  // Every granted regfile write must be the next entry the scoreboard expects.
  always @(negedge clk) begin
    if (!rst && rfWbckValid && rfWbckReady) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL wb_unexpected: got rdidx=%0d wdat=%h, required no write", rfWbckRdidx, rfWbckWdat);
      end else begin
        monExp = expQ.pop_front();
        if (rfWbckRdidx !== monExp.rdidx || rfWbckWdat !== monExp.wdat) begin
          failures++;
          $display("[TB] FAIL wb_data: got rdidx=%0d wdat=%h, required rdidx=%0d wdat=%h",
                   rfWbckRdidx, rfWbckWdat, monExp.rdidx, monExp.wdat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic setSrc(input int k, input logic [3:0] itag, input logic [31:0] wdat);
    srcValid[k]          = 1'b1;
    srcItag[k*4 +: 4]    = itag;
    srcWdat[k*32 +: 32]  = wdat;
  endtask

  task automatic setOitf(input logic empty, input logic [3:0] ptr, input logic rdwen, input logic [4:0] rdidx);
    oitfEmpty    = empty;
    oitfRetPtr   = ptr;
    oitfRetRdwen = rdwen;
    oitfRetRdidx = rdidx;
  endtask

  task automatic pushExp(input logic [4:0] rdidx, input logic [31:0] wdat);
    wbExp_t e;
    e.rdidx = rdidx;
    e.wdat  = wdat;
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    sample();
    checks++;
    if (srcReady !== 2'b11 || oitfRetEna !== 1'b0 || rfWbckValid !== 1'b0 || retCnt !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_state: got ready=%b ret_ena=%b wb_valid=%b ret_cnt=%0d, required 11 0 0 0",
               srcReady, oitfRetEna, rfWbckValid, retCnt);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    tick();
    setOitf(1'b0, 4'd0, 1'b1, 5'd5);
    rfWbckReady = 1'b1;
    setSrc(0, 4'd0, 32'hDEAD_BEEF);
    pushExp(5'd5, 32'hDEAD_BEEF);
    sample();
    checks++;
    if (srcReady !== 2'b11 || oitfRetEna !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_accept: got ready=%b ret_ena=%b, required 11 0", srcReady, oitfRetEna);
    end
    tick();
    srcValid = 2'b00;
    sample();
    checks++;
    if (rfWbckValid !== 1'b1 || rfWbckRdidx !== 5'd5 || rfWbckWdat !== 32'hDEAD_BEEF || oitfRetEna !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_wb: got valid=%b rdidx=%0d wdat=%h ret_ena=%b, required 1 5 deadbeef 1",
               rfWbckValid, rfWbckRdidx, rfWbckWdat, oitfRetEna);
    end
    tick();
    expCnt++;
    oitfEmpty = 1'b1;
    sample();
    checks++;
    if (retCnt !== 32'(expCnt) || oitfRetEna !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_cnt: got ret_cnt=%0d ret_ena=%b, required %0d 0", retCnt, oitfRetEna, expCnt);
    end
  endtask

  task automatic test_in_order();
    tick();
    setOitf(1'b0, 4'd0, 1'b1, 5'd3);
    pushExp(5'd3, 32'h2222_0000);
    pushExp(5'd4, 32'h1111_0001);
    srcValid = 2'b00;
    setSrc(1, 4'd1, 32'h1111_0001);
    tick();
    srcValid = 2'b00;
    setSrc(0, 4'd0, 32'h2222_0000);
    sample();
    checks++;
    if (rfWbckValid !== 1'b0 || oitfRetEna !== 1'b0 || srcReady !== 2'b01) begin
      failures++;
      $display("[TB] FAIL order_hold: got wb_valid=%b ret_ena=%b ready=%b, required 0 0 01",
               rfWbckValid, oitfRetEna, srcReady);
    end
    tick();
    srcValid = 2'b00;
    sample();
    checks++;
    if (rfWbckValid !== 1'b1 || rfWbckWdat !== 32'h2222_0000 || oitfRetEna !== 1'b1) begin
      failures++;
      $display("[TB] FAIL order_lsu_first: got valid=%b wdat=%h ret_ena=%b, required 1 22220000 1",
               rfWbckValid, rfWbckWdat, oitfRetEna);
    end
    tick();
    expCnt++;
    setOitf(1'b0, 4'd1, 1'b1, 5'd4);
    sample();
    checks++;
    if (rfWbckValid !== 1'b1 || rfWbckWdat !== 32'h1111_0001 || rfWbckRdidx !== 5'd4) begin
      failures++;
      $display("[TB] FAIL order_muldiv_second: got valid=%b rdidx=%0d wdat=%h, required 1 4 11110001",
               rfWbckValid, rfWbckRdidx, rfWbckWdat);
    end
    tick();
    expCnt++;
    oitfEmpty = 1'b1;
    sample();
    checks++;
    if (retCnt !== 32'(expCnt) || srcReady !== 2'b11) begin
      failures++;
      $display("[TB] FAIL order_cnt: got ret_cnt=%0d ready=%b, required %0d 11", retCnt, srcReady, expCnt);
    end
  endtask

  task automatic test_stall();
    tick();
    setOitf(1'b0, 4'd2, 1'b1, 5'd9);
    rfWbckReady = 1'b0;
    setSrc(0, 4'd2, 32'hCAFE_0003);
    pushExp(5'd9, 32'hCAFE_0003);
    tick();
    srcValid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++;
      if (rfWbckValid !== 1'b1 || rfWbckWdat !== 32'hCAFE_0003 || oitfRetEna !== 1'b0 || srcReady[0] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d]: got valid=%b wdat=%h ret_ena=%b ready0=%b, required 1 cafe0003 0 0",
                 i, rfWbckValid, rfWbckWdat, oitfRetEna, srcReady[0]);
      end
      tick();
    end
    rfWbckReady = 1'b1;
    sample();
    checks++;
    if (oitfRetEna !== 1'b1 || srcReady[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_release: got ret_ena=%b ready0=%b, required 1 1", oitfRetEna, srcReady[0]);
    end
    tick();
    expCnt++;
    sample();
    checks++;
    if (rfWbckValid !== 1'b0 || oitfRetEna !== 1'b0 || retCnt !== 32'(expCnt)) begin
      failures++;
      $display("[TB] FAIL stall_single_retire: got wb_valid=%b ret_ena=%b ret_cnt=%0d, required 0 0 %0d",
               rfWbckValid, oitfRetEna, retCnt, expCnt);
    end
    oitfEmpty = 1'b1;
  endtask

  task automatic test_no_rd_back_to_back();
    tick();
    setOitf(1'b0, 4'd3, 1'b0, 5'd0);
    rfWbckReady = 1'b0;
    setSrc(0, 4'd3, 32'hAAAA_AAAA);
    tick();
    setSrc(0, 4'd4, 32'h4444_4444);
    sample();
    checks++;
    if (oitfRetEna !== 1'b1 || rfWbckValid !== 1'b0 || srcReady[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL nord_retire: got ret_ena=%b wb_valid=%b ready0=%b, required 1 0 1",
               oitfRetEna, rfWbckValid, srcReady[0]);
    end
    tick();
    expCnt++;
    srcValid = 2'b00;
    setOitf(1'b0, 4'd4, 1'b1, 5'd10);
    rfWbckReady = 1'b1;
    pushExp(5'd10, 32'h4444_4444);
    sample();
    checks++;
    if (rfWbckValid !== 1'b1 || rfWbckWdat !== 32'h4444_4444 || oitfRetEna !== 1'b1) begin
      failures++;
      $display("[TB] FAIL nord_refill: got valid=%b wdat=%h ret_ena=%b, required 1 44444444 1",
               rfWbckValid, rfWbckWdat, oitfRetEna);
    end
    tick();
    expCnt++;
    oitfEmpty = 1'b1;
    sample();
    checks++;
    if (retCnt !== 32'(expCnt)) begin
      failures++;
      $display("[TB] FAIL nord_cnt: got ret_cnt=%0d, required %0d", retCnt, expCnt);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    oitfEmpty = 1'b1;
    setSrc(0, 4'd5, 32'h5555_5555);
    setSrc(1, 4'd6, 32'h6666_6666);
    tick();
    srcValid = 2'b00;
    sample();
    checks++;
    if (srcReady !== 2'b00) begin
      failures++;
      $display("[TB] FAIL rstmid_full: got ready=%b, required 00", srcReady);
    end
    tick();
    rst = 1'b1;
    setOitf(1'b0, 4'd5, 1'b1, 5'd1);
    sample();
    checks++;
    if (oitfRetEna !== 1'b0 || rfWbckValid !== 1'b0 || srcReady !== 2'b11) begin
      failures++;
      $display("[TB] FAIL rstmid_during: got ret_ena=%b wb_valid=%b ready=%b, required 0 0 11",
               oitfRetEna, rfWbckValid, srcReady);
    end
    tick();
    rst = 1'b0;
    expCnt = 0;
    sample();
    checks++;
    if (srcReady !== 2'b11 || retCnt !== 32'd0 || oitfRetEna !== 1'b0 || rfWbckValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_after: got ready=%b ret_cnt=%0d ret_ena=%b wb_valid=%b, required 11 0 0 0",
               srcReady, retCnt, oitfRetEna, rfWbckValid);
    end
    oitfEmpty = 1'b1;
  endtask

`ifdef LONGP_WBCK_ERR_EN
  task automatic test_err();
    tick();
    setOitf(1'b0, 4'd2, 1'b1, 5'd12);
    rfWbckReady = 1'b1;
    srcErr      = 2'b01;
    setSrc(0, 4'd2, 32'h0BAD_0BAD);
    tick();
    srcValid = 2'b00;
    srcErr   = 2'b00;
    sample();
    checks++;
    if (excpValid !== 1'b1 || excpItag !== 4'd2 || oitfRetEna !== 1'b1 || rfWbckValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_retire: got excp=%b itag=%0d ret_ena=%b wb_valid=%b, required 1 2 1 0",
               excpValid, excpItag, oitfRetEna, rfWbckValid);
    end
    tick();
    expCnt++;
    oitfEmpty = 1'b1;
    sample();
    checks++;
    if (excpValid !== 1'b0 || retCnt !== 32'(expCnt)) begin
      failures++;
      $display("[TB] FAIL err_after: got excp=%b ret_cnt=%0d, required 0 %0d", excpValid, retCnt, expCnt);
    end
  endtask
`endif

  initial begin
    rst          = 1'b1;
    srcValid     = 2'b00;
    srcItag      = '0;
    srcWdat      = '0;
    rfWbckReady  = 1'b1;
    setOitf(1'b1, 4'd0, 1'b1, 5'd0);
`ifdef LONGP_WBCK_ERR_EN
    srcErr       = 2'b00;
`endif
    test_reset();
    test_single();
    test_in_order();
    test_stall();
    test_no_rd_back_to_back();
`ifdef LONGP_WBCK_ERR_EN
    test_err();
`endif
    test_reset_mid();
    tick();
    sample();
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending writes, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
